// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle for the serial slice adder: operation in, result out,
// each side with its own valid/ready handshake.
interface serial_add_ctrl_if #(
  parameter int NIBBLES = 4
) ();
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Serial add/subtract: one 4-bit adder is time-shared over NIBBLES slices,
// LSB first, with the carry held in a register between slices.
module adder4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

module serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic            clk,
  input logic            rst,
  serial_add_ctrl_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a_r;
  logic [W-1:0]  bx_r;   // B already conditioned for subtract (~B)
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  sum_r;
  logic          cout_r;
  logic          ovf_r;

  logic [3:0] a_s, b_s, s_s;
  logic       c_s;

  assign a_s = a_r[4*idx +: 4];
  assign b_s = bx_r[4*idx +: 4];

  adder4bit u_add (
    .a    (a_s),
    .b    (b_s),
    .cin  (carry),
    .s    (s_s),
    .cout (c_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      bx_r   <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_r   <= bus.a;
          bx_r  <= bus.sub ? ~bus.b : bus.b;
          carry <= bus.sub;
          idx   <= '0;
          state <= RUN;
        end
        RUN: begin
          sum_r[4*idx +: 4] <= s_s;
          carry <= c_s;
          idx   <= idx + 1'b1;
          if (idx == IW'(NIBBLES - 1)) begin
            // Last slice: s_s[3] is the result sign bit.
            cout_r <= c_s;
            ovf_r  <= (a_r[W-1] == bx_r[W-1]) && (s_s[3] != a_r[W-1]);
            idx    <= '0;
            state  <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, meaning the number of 4-bit slices per operand (legal range 2..8).
REQ-002 The block SHALL have derived width W = 4*NIBBLES, which is not overridable.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the requester presents an operation.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-007 The block SHALL have port a, input, W bits: operand A.
REQ-008 The block SHALL have port b, input, W bits: operand B.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 selects A+B, 1 selects A-B.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is held and valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port sum, output, W bits: the result.
REQ-013 The block SHALL have port cout, output, 1 bit: carry out of the MSB slice (for sub, 1 means no borrow).
REQ-014 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow of the operation.

Function
REQ-015 The block SHALL compute every slice through exactly one instance of the team's adder4bit module, time-shared across slices; no other adder is permitted.
REQ-016 The block SHALL implement the states IDLE, RUN and DONE.
REQ-017 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0; in RUN and DONE, in_ready SHALL be 0.
REQ-018 On an IDLE cycle with in_valid=1, the block SHALL capture a, b and sub, clear the slice index to 0, load carry = sub, and go to RUN.
REQ-019 On an IDLE cycle with in_valid=0, the block SHALL remain in IDLE.
REQ-020 In each RUN cycle with index i, the adder inputs SHALL be A[4i+3:4i], B'[4i+3:4i] (B' = sub ? ~B : B) and the carry register.
REQ-021 In each RUN cycle, the slice sum SHALL be written to sum[4i+3:4i], the carry register SHALL take the adder cout, and i SHALL increment.
REQ-022 When i = NIBBLES-1, the block SHALL go to DONE on the next edge, with cout = the final adder cout and ovf = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]).
REQ-023 Latency SHALL be exactly NIBBLES+1 cycles from the accepting edge to the first cycle with out_valid=1.
REQ-024 In DONE, out_valid SHALL be 1, and sum, cout and ovf SHALL be held stable until out_ready=1.
REQ-025 A DONE cycle with out_ready=1 SHALL return the block to IDLE; the next operation SHALL NOT be accepted in that same cycle.
REQ-026 Changes on a, b or sub after acceptance SHALL NOT affect the result in progress.
REQ-027 in_valid SHALL be ignored outside IDLE; no operation is queued.
REQ-028 out_ready SHALL be ignored outside DONE.
REQ-029 Arithmetic SHALL be modulo 2^W; wrap-around is reported only through cout and ovf.
REQ-030 sum, cout and ovf SHALL retain their last completed values while in IDLE.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, slice index 0, carry 0, sum 0, cout 0, ovf 0, out_valid 0 and in_ready 1, in any state.
REQ-032 rst SHALL take priority over every handshake in the same cycle.
REQ-033 A reset during RUN or DONE SHALL discard the operation, and no out_valid pulse SHALL follow.
REQ-034 in_ready SHALL be 1 in the first cycle after rst is released.

Verification
REQ-035 Addition: NIBBLES=4, a=16'h1234, b=16'h4321, sub=0 -> exactly 5 cycles later sum=16'h5555, cout=0, ovf=0, out_valid=1.
REQ-036 Carry ripple: a=16'hFFFF, b=16'h0001, sub=0 -> sum=16'h0000, cout=1, ovf=0.
REQ-037 Subtraction and overflow: a=16'h0003, b=16'h0005, sub=1 -> sum=16'hFFFE, cout=0, ovf=0; then a=16'h7FFF, b=16'hFFFF, sub=1 -> sum=16'h8000, ovf=1.
REQ-038 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, outputs stable, in_ready stays 0, in_valid pulses ignored; release out_ready -> IDLE next cycle.
REQ-039 Reset mid-RUN: assert rst at slice index 2 -> next cycle in IDLE with all outputs 0, and no out_valid seen afterwards.
REQ-040 Back-to-back operations: in_valid held high with random operands for 1000 operations -> each result matches (a ± b) mod 2^16 with correct cout and ovf, and throughput is one result per NIBBLES+2 cycles when out_ready=1.
